aes_key_sched: RTL and testbench

Iterative AES key-expansion engine that replaces the fixed round-constant lookup with a sequential generator. It computes the Rcon sequence in-register by GF(2^8) doubling and emits the full expanded key schedule, one 32-bit word per accepted beat. It is parametrised for AES-128, AES-192 and AES-256. It sits between the key register and the round-key consumer, which is either a round-key RAM or the cipher datapath.

---
 rtl/aes_pkg.sv | 27 ++
 rtl/aes_sbox.sv | 45 ++++
 rtl/aes_key_sched.sv | 145 ++++++++++++++
 tb/tb_aes_key_sched.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round-constant seed, GF(2^8) doubling, key-schedule
// FSM encodings and the key-length legality check.
package aes_pkg;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] EXPAND = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    logic [7:0] r;
    if (b[7]) begin
      r = {b[6:0], 1'b0} ^ RCON_POLY;
    end else begin
      r = {b[6:0], 1'b0};
    end
    return r;
  endfunction

  function automatic bit legal_nk(input int nk);
    return (nk == 4) || (nk == 6) || (nk == 8);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform. Computed rather than tabulated so it can be shared freely.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] m, input logic [7:0] n);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = m;
    for (int i = 0; i < 8; i++) begin
      if (n[i]) begin
        p = p ^ x;
      end else begin
        p = p;
      end
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 == x^-1 for nonzero x, and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] m);
    logic [7:0] r;
    r = m;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), m);
    end
    return gf_mul(r, r);
  endfunction

  logic [7:0] inv_s;

  // inverse followed by the affine transform
  always_comb begin
    inv_s = gf_inv(a);
    y = inv_s ^ {inv_s[6:0], inv_s[7]} ^ {inv_s[5:0], inv_s[7:6]}
              ^ {inv_s[4:0], inv_s[7:5]} ^ {inv_s[3:0], inv_s[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES key expansion: one schedule word per accepted beat, Rcon
// generated in-register by GF(2^8) doubling. NK selects AES-128/192/256.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [32*NK-1:0] key_in,
  input  logic             word_ready,
  output logic             word_valid,
  output logic [31:0]      word_out,
  output logic [5:0]       word_idx,
  output logic [3:0]       round_idx,
  output logic             busy,
  output logic             done
);

  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK_W     = 6'(NK);
  localparam logic [6:0] NW_W     = 7'(NW);
  localparam logic [5:0] LAST_IDX = 6'(NW - 1);
  localparam logic [5:0] LAST_KEY = 6'(NK - 1);
  localparam logic [2:0] POS_LAST = 3'(NK - 1);

  if (!legal_nk(NK)) begin : g_bad_nk
    $error("aes_key_sched: NK must be 4, 6 or 8");
  end

  // Together with word_out this holds the last NK words; window_r[0] is w[i-NK+1].
  logic [31:0] window_r [NK-1];
  logic [1:0]  state_r;
  logic [7:0]  rcon_r;
  logic [2:0]  pos_r;

  logic        accept_s;
  logic        rcon_adv_s;
  logic [5:0]  idx_nx_s;
  logic [2:0]  pos_nx_s;
  logic [31:0] sub_in_s;
  logic [31:0] sub_out_s;
  logic [31:0] temp_s;
  logic [31:0] next_word_s;

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (.a(sub_in_s[8*b +: 8]), .y(sub_out_s[8*b +: 8]));
  end

  // next-word datapath: w[n] from the window and w[n-1] (currently in word_out)
  always_comb begin
    accept_s   = word_valid && word_ready;
    idx_nx_s   = word_idx + 6'd1;
    pos_nx_s   = (pos_r == POS_LAST) ? 3'd0 : pos_r + 3'd1;
    rcon_adv_s = accept_s && (pos_r == 3'd0) && (word_idx >= NK_W)
                 && (({1'b0, word_idx} + {1'b0, NK_W}) < NW_W);
    if (pos_nx_s == 3'd0) begin
      sub_in_s = {word_out[23:0], word_out[31:24]};
    end else begin
      sub_in_s = word_out;
    end
    if (idx_nx_s < NK_W) begin
      temp_s = 32'h0000_0000;
    end else if (pos_nx_s == 3'd0) begin
      temp_s = sub_out_s ^ {rcon_r, 24'h00_0000};
    end else if ((NK == 8) && (pos_nx_s == 3'd4)) begin
      temp_s = sub_out_s;
    end else begin
      temp_s = word_out;
    end
    next_word_s = window_r[0] ^ temp_s;
  end

  // FSM, window shift, Rcon generator and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      rcon_r     <= RCON_INIT;
      pos_r      <= 3'd0;
      word_valid <= 1'b0;
      word_out   <= 32'h0000_0000;
      word_idx   <= 6'd0;
      round_idx  <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int k = 0; k < NK-1; k++) begin
        window_r[k] <= 32'h0000_0000;
      end
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int k = 0; k < NK-1; k++) begin
              window_r[k] <= key_in[32*(NK-1-k)-1 -: 32];
            end
            word_out   <= key_in[32*NK-1 -: 32];
            word_idx   <= 6'd0;
            round_idx  <= 4'd0;
            pos_r      <= 3'd0;
            rcon_r     <= RCON_INIT;
            word_valid <= 1'b1;
            busy       <= 1'b1;
            state_r    <= LOAD;
          end
        end
        LOAD, EXPAND: begin
          if (accept_s) begin
            for (int k = 0; k < NK-2; k++) begin
              window_r[k] <= window_r[k+1];
            end
            window_r[NK-2] <= word_out;
            if (rcon_adv_s) begin
              rcon_r <= xtime(rcon_r);
            end
            if (word_idx == LAST_IDX) begin
              word_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state_r    <= DONE;
            end else begin
              word_out  <= next_word_s;
              word_idx  <= idx_nx_s;
              round_idx <= idx_nx_s[5:2];
              pos_r     <= pos_nx_s;
              if ((state_r == LOAD) && (word_idx == LAST_KEY)) begin
                state_r <= EXPAND;
              end
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// Bench for aes_key_sched: one instance per key length, checked against a
// table-based key-expansion model, FIPS-197 known answers and handshake rules.
module tb_aes_key_sched;

  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [79:0] RCON_FLAT = 80'h01020408102040801b36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] key0;
  logic [191:0] key1;
  logic [255:0] key2;
  logic         start [3];
  logic         ready [3];
  logic         valid [3];
  logic [31:0]  wout  [3];
  logic [5:0]   widx  [3];
  logic [3:0]   ridx  [3];
  logic         busy  [3];
  logic         done  [3];

  aes_key_sched #(.NK(4)) u_dut4 (.clk(clk), .rst(rst), .start(start[0]), .key_in(key0),
    .word_ready(ready[0]), .word_valid(valid[0]), .word_out(wout[0]), .word_idx(widx[0]),
    .round_idx(ridx[0]), .busy(busy[0]), .done(done[0]));
  aes_key_sched #(.NK(6)) u_dut6 (.clk(clk), .rst(rst), .start(start[1]), .key_in(key1),
    .word_ready(ready[1]), .word_valid(valid[1]), .word_out(wout[1]), .word_idx(widx[1]),
    .round_idx(ridx[1]), .busy(busy[1]), .done(done[1]));
  aes_key_sched #(.NK(8)) u_dut8 (.clk(clk), .rst(rst), .start(start[2]), .key_in(key2),
    .word_ready(ready[2]), .word_valid(valid[2]), .word_out(wout[2]), .word_idx(widx[2]),
    .round_idx(ridx[2]), .busy(busy[2]), .done(done[2]));

  int checks = 0;
  int failures = 0;
  logic [31:0]  exp_w [60];
  logic [31:0]  cap [3][60];
  logic [7:0]   rq [$];
  logic [255:0] keys [3];

  typedef struct {
    int          g;
    int          idx;
    logic [31:0] w;
  } kat_t;
  kat_t kats [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = SBOX_FLAT[2047 - 8*int'(w[8*b +: 8]) -: 8];
    end
    return r;
  endfunction

  // FIPS-197 key expansion over a plain array
  function automatic void model(input int nk, input logic [255:0] k);
    logic [255:0] t;
    logic [31:0]  tmp;
    for (int i = 0; i < 4*(nk+7); i++) begin
      if (i < nk) begin
        t = k >> (32*(nk-1-i));
        exp_w[i] = t[31:0];
      end else begin
        tmp = exp_w[i-1];
        if (i % nk == 0) begin
          tmp = subw({tmp[23:0], tmp[31:24]}) ^ {RCON_FLAT[79 - 8*(i/nk - 1) -: 8], 24'h0};
        end else if (nk == 8 && i % nk == 4) begin
          tmp = subw(tmp);
        end
        exp_w[i] = exp_w[i-nk] ^ tmp;
      end
    end
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  task automatic set_key(input int g, input logic [255:0] k);
    case (g)
      0: key0 = k[127:0];
      1: key1 = k[191:0];
      default: key2 = k;
    endcase
  endtask

  // one full expansion on instance g; rnd toggles word_ready, hold keeps start high
  task automatic run_exp(input int g, input bit rnd, input bit hold, input logic [255:0] k);
    int nk = 4 + 2*g;
    int nw = 4*(nk+7);
    int beats = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    bit r;
    logic [31:0] hw;
    logic [5:0]  hi;
    logic [7:0]  rc;
    model(nk, k);
    rq.delete();
    @(negedge clk);
    set_key(g, k);
    start[g] = 1'b1;
    ready[g] = 1'b0;
    @(negedge clk);
    if (hold) set_key(g, ~k);
    else start[g] = 1'b0;
    chk("busy_rise", 64'(busy[g]), 64'd1);
    chk("first_valid", 64'(valid[g]), 64'd1);
    while (beats < nw && cyc < 1000) begin
      if (g == 0) begin
        rc = u_dut4.rcon_r;
        if (rq.size() == 0 || rq[rq.size()-1] != rc) rq.push_back(rc);
      end
      if (stalled) begin
        chk("stall_word", 64'(wout[g]), 64'(hw));
        chk("stall_idx", 64'(widx[g]), 64'(hi));
      end
      chk("no_early_done", 64'(done[g]), 64'd0);
      chk("valid_held", 64'(valid[g]), 64'd1);
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ready[g] = r;
      if (valid[g] && r) begin
        chk("word_idx", 64'(widx[g]), 64'(beats));
        chk("round_idx", 64'(ridx[g]), 64'(beats/4));
        cap[g][beats] = wout[g];
        beats++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        hw = wout[g];
        hi = widx[g];
      end
      @(negedge clk);
      cyc++;
    end
    ready[g] = 1'b0;
    chk("beat_count", 64'(beats), 64'(nw));
    chk("done_pulse", 64'(done[g]), 64'd1);
    chk("busy_in_done", 64'(busy[g]), 64'd0);
    chk("valid_in_done", 64'(valid[g]), 64'd0);
    @(negedge clk);
    if (hold) start[g] = 1'b0;
    chk("done_one_cycle", 64'(done[g]), 64'd0);
    chk("no_restart_valid", 64'(valid[g]), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("idle_done", 64'(done[g]), 64'd0);
      chk("idle_busy", 64'(busy[g]), 64'd0);
    end
    for (int i = 0; i < nw; i++) chk("word", 64'(cap[g][i]), 64'(exp_w[i]));
    if (g == 0) begin
      chk("rcon_count", 64'(rq.size()), 64'd10);
      for (int i = 0; i < rq.size() && i < 10; i++)
        chk("rcon_seq", 64'(rq[i]), 64'(RCON_FLAT[79 - 8*i -: 8]));
    end
  endtask

  initial begin
    int cyc;
    keys[0] = 256'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    keys[1] = 256'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b;
    keys[2] = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
    kats[0] = '{0,  4, 32'ha0fafe17};
    kats[1] = '{0, 43, 32'hb6630ca6};
    kats[2] = '{1,  6, 32'hfe0c91f7};
    kats[3] = '{1, 51, 32'h01002202};
    kats[4] = '{2,  8, 32'h9ba35411};
    kats[5] = '{2, 59, 32'h706c631e};

    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0;
      ready[g] = 1'b0;
      set_key(g, '0);
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_valid", 64'(valid[g]), 64'd0);
      chk("rst_word", 64'(wout[g]), 64'd0);
      chk("rst_idx", 64'(widx[g]), 64'd0);
      chk("rst_busy", 64'(busy[g]), 64'd0);
      chk("rst_done", 64'(done[g]), 64'd0);
    end
    chk("rst_rcon", 64'(u_dut4.rcon_r), 64'h01);
    rst = 1'b0;

    for (int g = 0; g < 3; g++) run_exp(g, 1'b0, 1'b0, keys[g]);
    for (int i = 0; i < 6; i++)
      chk("kat", 64'(cap[kats[i].g][kats[i].idx]), 64'(kats[i].w));

    // backpressure on the AES-128 key must reproduce the same schedule
    run_exp(0, 1'b1, 1'b0, keys[0]);

    // abort at word 20 with a simultaneous start, then restart cleanly
    @(negedge clk);
    set_key(0, keys[0]);
    start[0] = 1'b1;
    ready[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    cyc = 0;
    while (widx[0] != 6'd20 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reach", 64'(widx[0]), 64'd20);
    rst = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start[0] = 1'b0;
    ready[0] = 1'b0;
    chk("abort_valid", 64'(valid[0]), 64'd0);
    chk("abort_word", 64'(wout[0]), 64'd0);
    chk("abort_idx", 64'(widx[0]), 64'd0);
    chk("abort_ridx", 64'(ridx[0]), 64'd0);
    chk("abort_busy", 64'(busy[0]), 64'd0);
    chk("abort_rcon", 64'(u_dut4.rcon_r), 64'h01);
    repeat (5) begin
      chk("abort_no_done", 64'(done[0]), 64'd0);
      @(negedge clk);
    end
    run_exp(0, 1'b0, 1'b0, rand_key());

    // start held high through the whole run and the DONE cycle
    run_exp(1, 1'b0, 1'b1, rand_key());
    run_exp(2, 1'b1, 1'b1, rand_key());

    for (int g = 0; g < 3; g++) run_exp(g, 1'b1, 1'b0, rand_key());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
